decoder_seq: RTL
================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, meaning select width; OUT_W = 2**SEL_W decoded lines.
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1; when 1 the asserted line on dout is 0 and idle lines are 1; when 0 polarity is inverted.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  block enable; low forces idle.
REQ-007 sel  in  SEL_W  line index to assert.
REQ-008 sel_valid  in  1  sel request.
REQ-009 sel_ready  out  1  combinational: en & ~busy & ~scan_start.
REQ-010 scan_start  in  1  request auto-scan of all lines (only with DECODER_SCAN_EN).
REQ-011 minterm_mask  in  OUT_W  selects lines contributing to f.
REQ-012 dout  out  OUT_W  registered one-hot (or one-cold) decode.
REQ-013 idx  out  SEL_W  registered index of the active line, 0 when none.
REQ-014 f  out  1  registered minterm function: 1 iff a line is active and minterm_mask[idx]=1.
REQ-015 busy  out  1  registered, 1 while in SCAN.
REQ-016 scan_done  out  1  registered one-cycle pulse at normal scan completion.

Function
REQ-017 The FSM SHALL have states IDLE (no line active), HOLD (one line held), SCAN (walking lines).
REQ-018 In IDLE, dout SHALL be all-inactive, idx=0, f=0, busy=0.
REQ-019 A handshake (sel_valid & sel_ready) SHALL, at that edge, move to HOLD with line sel active on dout and idx=sel; latency one cycle.
REQ-020 In HOLD, a new handshake SHALL replace the active line at the next edge; no cycle of all-inactive between lines.
REQ-021 en=0 in any state SHALL return to IDLE at the next edge; sel_valid is ignored (sel_ready=0).
REQ-022 scan_start with en=1 and busy=0 (from IDLE or HOLD) SHALL enter SCAN with line 0 active and busy=1 at the next edge.
REQ-023 In SCAN, idx SHALL increment by one each cycle; after line OUT_W-1 has been active one cycle, the next edge SHALL enter IDLE with scan_done=1 for exactly that cycle.
REQ-024 A scan SHALL occupy exactly OUT_W cycles with busy=1.
REQ-025 scan_start and sel_valid in the same cycle: scan wins, sel is not accepted.
REQ-026 en falling mid-scan SHALL abort to IDLE at the next edge without a scan_done pulse.
REQ-027 f SHALL be computed at each edge from the next-state index and the minterm_mask sampled at that edge; f=0 whenever no line is active.
REQ-028 Exactly zero or one dout line SHALL be active in every cycle.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE: dout all-inactive (all 1s if ACTIVE_LOW=1), idx=0, f=0, busy=0, scan_done=0; reset overrides every other input, including mid-scan.
REQ-030 After rst deasserts, the first handshake SHALL be accepted normally in the next cycle.

Configuration
REQ-031 Macro DECODER_SCAN_EN SHALL, when defined, include the SCAN state, scan_start, busy and scan_done behaviour as above.
REQ-032 Without DECODER_SCAN_EN, scan_start SHALL be ignored, busy and scan_done SHALL be tied to 0, and sel_ready SHALL equal en.

Verification (SEL_W=3, ACTIVE_LOW=1, DECODER_SCAN_EN defined)
REQ-033 rst=1 one cycle -> dout=8'hFF, idx=0, f=0, busy=0.
REQ-034 en=1, sel=5 with sel_valid, mask=8'b0010_0000 -> next cycle dout=8'hDF, idx=5, f=1; then sel=2 -> dout=8'hFB, f=0 with no 8'hFF cycle between.
REQ-035 scan_start from IDLE, mask=8'hAA -> dout walks FE,FD,FB,...,7F over 8 cycles with f=0,1,0,1,...; then dout=FF with scan_done=1 for one cycle.
REQ-036 scan_start and sel_valid (sel=3) in the same cycle -> scan begins at line 0, sel_ready=0, line 3 is not held.
REQ-037 en=0 at scan step 4 -> dout=FF next cycle, busy=0, no scan_done; rst mid-HOLD -> dout=FF next cycle.
REQ-038 Rebuild without DECODER_SCAN_EN, pulse scan_start -> dout unchanged, busy=0, scan_done=0.

Source files
------------

// File: rtl/decoder_seq.sv
// decoder_seq: registered line decoder with hold, optional auto-scan (DECODER_SCAN_EN) and minterm output
module decoder_seq #(
   parameter int SEL_W = 3,
   parameter int ACTIVE_LOW = 1,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   input  logic             sel_valid,
   output logic             sel_ready,
   input  logic             scan_start,
   input  logic [OUT_W-1:0] minterm_mask,
   output logic [OUT_W-1:0] dout,
   output logic [SEL_W-1:0] idx,
   output logic             f,
   output logic             busy,
   output logic             scan_done
);
`ifdef DECODER_SCAN_EN
   localparam bit SCAN_EN = 1'b1;
`else
   localparam bit SCAN_EN = 1'b0;
`endif
   localparam logic [OUT_W-1:0] NONE = (ACTIVE_LOW != 0) ? '1 : '0;
   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
   state_t state;
   logic scan_go;
   logic [SEL_W-1:0] nidx;
   function automatic logic [OUT_W-1:0] line(input logic [SEL_W-1:0] i);
      return (ACTIVE_LOW != 0) ? ~(OUT_W'(1) << i) : (OUT_W'(1) << i);
   endfunction
   assign scan_go = SCAN_EN && scan_start && !busy;
   assign sel_ready = en && !busy && !(SCAN_EN && scan_start);
   assign nidx = idx + SEL_W'(1);
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state <= IDLE;
         dout <= NONE;
         idx <= '0;
         f <= 1'b0;
         busy <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         if (state == SCAN) begin
            busy <= !(&idx);
            scan_done <= &idx;
            if (&idx) begin
               state <= IDLE;
               dout <= NONE;
               idx <= '0;
               f <= 1'b0;
            end else begin
               idx <= nidx;
               dout <= line(nidx);
               f <= minterm_mask[nidx];
            end
         end else if (scan_go) begin
            state <= SCAN;
            busy <= 1'b1;
            idx <= '0;
            dout <= line('0);
            f <= minterm_mask[0];
         end else if (sel_valid && sel_ready) begin
            state <= HOLD;
            idx <= sel;
            dout <= line(sel);
            f <= minterm_mask[sel];
         end else begin
            // held line re-evaluates f against the mask seen at this edge
            f <= (state == HOLD) && minterm_mask[idx];
         end
      end
   end
endmodule
